// File: rtl/qlm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | qlm_pkg                                                          |
// | Shared types, constants and helpers for the qlm_acc accumulator. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package qlm_pkg;

  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Callers narrow the result to their own width with a size cast.
  function automatic logic [63:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(64-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage
`default_nettype wire

// File: rtl/qlm_acc_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | qlm_acc_if                                                       |
// | Job control, product stream and result port of qlm_acc.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface qlm_acc_if
  import qlm_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int LEN_W = 8
) ();

  logic              start_i;
  logic [LEN_W-1:0]  len_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [PROD_W-1:0] prod_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [ACC_W-1:0]  acc_o;
  logic              sat_o;
  logic              busy_o;

  modport master (
    output start_i, len_i, in_valid_i, prod_i, out_ready_i,
    input  in_ready_o, out_valid_o, acc_o, sat_o, busy_o
  );

  modport slave (
    input  start_i, len_i, in_valid_i, prod_i, out_ready_i,
    output in_ready_o, out_valid_o, acc_o, sat_o, busy_o
  );

endinterface
`default_nettype wire

// File: rtl/qlm_acc_sat_add.sv
`default_nettype none
// +------------------------------------------------------------------+
// | qlm_sat_add                                                      |
// | Combinational saturating add of a 16-bit product into ACC_W.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module qlm_sat_add
  import qlm_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  wire logic [ACC_W-1:0]  acc,
  input  wire logic [PROD_W-1:0] prod,
  input  wire logic              cin,
  output logic      [ACC_W-1:0]  sum,
  output logic                   ovf
);

  localparam logic [ACC_W-1:0] c_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_min = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] w_acc_ext;
  logic [ACC_W:0] w_add_ext;
  logic [ACC_W:0] w_raw;

  assign w_acc_ext = {acc[ACC_W-1], acc};
  assign w_add_ext = (ACC_W+1)'(sext_prod(prod));
  assign w_raw     = w_acc_ext + w_add_ext + {{ACC_W{1'b0}}, cin};

  // The extra top bit holds the true sign, so a disagreement with the
  // ACC_W-bit sign bit means the result left the representable range.
  always_comb begin
    ovf = w_raw[ACC_W] ^ w_raw[ACC_W-1];
    sum = w_raw[ACC_W-1:0];
    if (ovf) begin
      sum = w_raw[ACC_W] ? c_min : c_max;
    end
  end

endmodule
`default_nettype wire

// File: rtl/qlm_acc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | qlm_acc                                                          |
// | Streaming saturating dot-product accumulator behind QLM_w4q2.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module qlm_acc
  import qlm_pkg::*;
#(
  parameter int ACC_W   = 20,
  parameter int LEN_W   = 8,
  parameter int CORR_1C = 1
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  qlm_acc_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic             r_sat;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;
  logic             w_accept;
  logic             w_cin;
  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;

  assign w_accept = bus.in_valid_i & w_in_ready;
  assign w_cin    = (CORR_1C != 0) ? bus.prod_i[PROD_W-1] : 1'b0;

  qlm_sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc  (r_acc),
    .prod (bus.prod_i),
    .cin  (w_cin),
    .sum  (w_sum),
    .ovf  (w_ovf)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start_i) begin
          w_state_nxt = (bus.len_i == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_accept && (r_cnt == LEN_W'(1))) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == ST_ACCUM);
    w_out_valid = (r_state == ST_DONE);
    w_busy      = (r_state == ST_ACCUM) || (r_state == ST_DONE);
  end

  // Sat is sticky across the job; only a new start clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (bus.start_i) begin
        r_acc <= '0;
        r_sat <= 1'b0;
        r_cnt <= bus.len_i;
      end
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_sat <= r_sat | w_ovf;
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  assign bus.in_ready_o  = w_in_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.busy_o      = w_busy;
  assign bus.acc_o       = r_acc;
  assign bus.sat_o       = r_sat;

endmodule
`default_nettype wire

// File: doc/qlm_acc.md
Name: qlm_acc

Overview:
- Streaming signed accumulator directly downstream of the 8-bit approximate log multiplier (QLM_w4q2).
- Consumes its 16-bit sign-magnitude-via-ones'-complement products one per cycle over a valid/ready handshake.
- Sums a software-programmed number of products into a saturating accumulator and presents the dot-product result on a valid/ready output port.
- Used to build approximate dot products / MAC arrays around the combinational multiplier.

Parameters:
- ACC_W, 20, accumulator and result width (signed, two's complement); must be >= 17.
- LEN_W, 8, width of the job length field (max 2^LEN_W-1 products per job).
- CORR_1C, 1, when 1 each product is interpreted as ones' complement (value = prod_i + prod_i[15]); when 0 as plain two's complement.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin a job; sampled only in IDLE.
- len_i  in  LEN_W  number of products in the job; sampled with start_i.
- in_valid_i  in  1  product valid.
- in_ready_o  out  1  block accepts a product this cycle.
- prod_i  in  16  product word from the multiplier.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer takes result.
- acc_o  out  ACC_W  signed accumulated result.
- sat_o  out  1  result saturated at least once during the job.
- busy_o  out  1  high in ACCUM or DONE.

Behaviour:
- Reset (rst_i=1 at edge): state IDLE, accumulator=0, remaining count=0, in_ready_o=0, out_valid_o=0, acc_o=0, sat_o=0, busy_o=0. Reset mid-job aborts silently; no result is emitted.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start_i=1 and len_i!=0 -> ACCUM; clear accumulator and sat; load count=len_i.
  - start_i=1 and len_i=0 -> DONE directly with acc=0, sat=0.
  - Otherwise stay.
- ACCUM:
  - in_ready_o=1 (registered-state decode, not combinational on inputs).
  - A product is accepted on an edge where in_valid_i & in_ready_o. The accumulator updates on that same edge and count decrements.
  - When the accepted product makes count reach 0 -> DONE. out_valid_o is high the next cycle, i.e. one cycle after the last accept.
  - start_i is ignored.
- DONE:
  - out_valid_o=1; in_ready_o=0; acc_o and sat_o held stable.
  - out_ready_i=1 -> IDLE; out_valid_o drops the next cycle.
  - start_i in the same cycle is ignored; a new job may start from IDLE at the earliest one cycle later.
- Arithmetic:
  - Addend = sign-extend(prod_i) to ACC_W+1, plus carry-in prod_i[15] when CORR_1C=1. Example: 16'hFFF0 -> -15.
  - The sum is computed at ACC_W+1 bits. On signed overflow, clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and set sat (sticky until the next job start).
  - Subsequent products add to the clamped value.
- acc_o is driven from the accumulator register; it is valid only when out_valid_o=1, and its value is otherwise unspecified but deterministic.
- Cycles where in_valid_i=0 in ACCUM leave all state unchanged (bubbles allowed, any count).

Decomposition:
- Shared package qlm_pkg:
  - state enum (IDLE/ACCUM/DONE);
  - constant PROD_W=16;
  - helper function sign-extending PROD_W to a given width.
- One sub-module qlm_sat_add: combinational saturating adder (ACC_W accumulator + 16-bit addend + carry-in), outputs sum and overflow flag.
- FSM, counter and handshake stay in qlm_acc.

Test Plan:
- Basic sum: len=3, products 16'h0010, 16'h0020, 16'h0005 back-to-back -> out_valid_o one cycle after third accept, acc_o=53, sat_o=0.
- Ones' complement: CORR_1C=1, len=2, products 16'hFFF0, 16'h0005 -> acc_o=-10. With CORR_1C=0 -> acc_o=-11.
- Saturation: ACC_W=20, len=20, all products 16'h7FFF -> acc_o=524287 (20'h7FFFF), sat_o=1. Then a new job of len=1 with 16'h0001 -> acc_o=1, sat_o=0.
- Backpressure/bubbles: len=4 with in_valid_i toggled randomly and out_ready_i held 0 for 5 cycles in DONE -> acc_o/out_valid_o stable throughout; exactly 4 accepts; IDLE one cycle after out_ready_i=1.
- len_i=0 and ignored start: start with len=0 -> DONE next cycle with acc_o=0. Pulse start_i while in ACCUM/DONE -> no effect on count or result.
- Reset mid-job: len=5, assert rst_i after 2 accepts -> next cycle all outputs at reset values, no out_valid_o. Then a fresh job len=1 with 16'h0003 -> acc_o=3.
